ret_addr_stack: RTL and testbench
=================================

Name: ret_addr_stack

Overview:
Hardware return-address stack (LIFO) for the 8-bit multi-cycle microcontroller. On CALL, the control unit pushes the already-incremented PC (the PC+1 value from the incrementer). On RET, it pops that value back into the PC. The block tracks depth and full/empty state, and flags overflow and underflow so the control unit can trap.

Parameters:
ADDR_W, 8, width of a stored return address (matches PC width)
DEPTH, 8, number of entries; power of two, minimum 2
CNT_W, 4, width of count output; must hold the value DEPTH (log2(DEPTH)+1)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
push  in  1  CALL strobe, one cycle, write push_addr on top
push_addr  in  ADDR_W  return address (PC+1) to store
pop  in  1  RET strobe, one cycle, remove top entry
clr_err  in  1  clears sticky overflow/underflow
pop_addr  out  ADDR_W  registered popped address
pop_valid  out  1  one-cycle pulse, pop_addr updated this cycle
top_addr  out  ADDR_W  combinational view of current top entry (0 when empty)
count  out  CNT_W  current number of entries
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  sticky: push rejected or overwritten while full
underflow  out  1  sticky: pop while empty

Behaviour:
- Reset (rst=1 at clk edge) sets pop_addr=0, pop_valid=0, count=0, overflow=0, underflow=0, and stack pointer sp=0.
- Reset does not clear storage contents. top_addr is forced to 0 while empty.
- Reset has priority over all other inputs, including mid-sequence push/pop.
- Storage is DEPTH x ADDR_W registers. sp points to the next free slot. The top entry is mem[sp-1].
- Push only (push=1, pop=0), not full: mem[sp] <= push_addr, sp++, count++. Visible on top_addr the next cycle.
- Pop only, not empty: pop_addr <= mem[sp-1], pop_valid=1 for exactly one cycle, sp--, count--. Pop latency is 1 cycle.
- Push+pop in the same cycle, not empty: pop_addr <= old top, pop_valid=1. mem[sp-1] <= push_addr. sp and count are unchanged. This holds when full too; overflow is not set.
- Push+pop in the same cycle, empty: the push is performed (count becomes 1). underflow is set, pop_valid=0, and pop_addr is held.
- Pop while empty (no push): no state change except underflow <= 1. pop_valid=0, pop_addr held.
- Push while full (no pop), default build: the push is discarded, overflow <= 1, and contents and count are unchanged.
- clr_err=1 clears both sticky flags that cycle. A flag-setting event in the same cycle wins, so the flag stays 1.
- sp arithmetic is modulo DEPTH. count saturates at DEPTH and 0 and never wraps.
- empty and full are decoded combinationally from count.
- pop_valid is low in every cycle in which no successful pop occurred.

Optional Feature:
RAS_WRAP_EN
- Defined: push while full overwrites the oldest entry (circular buffer). mem[sp] <= push_addr, sp increments modulo DEPTH, count stays DEPTH, and overflow <= 1 to record the lost entry. Subsequent pops return the newest DEPTH entries in LIFO order; the final one of those pops reaches empty.
- Undefined: push while full is rejected, as described in Behaviour.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 and pop three times. pop_addr must be 0x33, 0x22, 0x11, each with a single-cycle pop_valid one cycle after pop. count goes 3→0 and empty=1 at the end.
- From empty, pop -> underflow=1, pop_valid=0, pop_addr unchanged, count=0. Then clr_err -> underflow=0.
- Push 8 values 0x01..0x08 (full=1), then push 0x99.
  - Default build: overflow=1, count=8, and eight pops yield 0x08..0x01.
  - RAS_WRAP_EN build: eight pops yield 0x99, 0x08..0x02.
- Push 0x40 and 0x41, then assert push=1 with 0x50 and pop=1 in the same cycle -> pop_addr=0x41, pop_valid=1, count=2, top_addr=0x50. Next pop returns 0x50.
- Push 0xA0 and 0xA1, then assert rst together with push=1 and 0xA2 -> count=0, empty=1, top_addr=0, flags 0, pop_valid=0. A pop on the next cycle sets underflow.
- With the stack empty, assert push=1 with 0x77 and pop=1 -> count=1, top_addr=0x77, underflow=1, pop_valid=0.

Source files
------------

// File: rtl/ret_addr_stack.sv
// Return-address stack (LIFO) for the 8-bit microcontroller: CALL pushes PC+1, RET pops it.
// Optional build macro RAS_WRAP_EN: push while full overwrites the oldest entry instead of being dropped.
module ret_addr_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] pop_addr,
  output logic              pop_valid,
  output logic [ADDR_W-1:0] top_addr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_sp;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_pop_addr;
  logic              r_pop_valid;
  logic              r_ovf;
  logic              r_unf;

  logic [PTR_W-1:0]  w_top_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wr_idx;
  logic              w_sp_inc;
  logic              w_sp_dec;
  logic              w_cnt_inc;
  logic              w_cnt_dec;
  logic              w_do_pop;
  logic              w_set_ovf;
  logic              w_set_unf;

  assign w_top_idx = r_sp - PTR_W'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = r_sp;
    w_sp_inc  = 1'b0;
    w_sp_dec  = 1'b0;
    w_cnt_inc = 1'b0;
    w_cnt_dec = 1'b0;
    w_do_pop  = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (push && pop) begin
      if (w_empty) begin
        // Nothing to return: the CALL half still lands, the RET half traps.
        w_wr_en   = 1'b1;
        w_sp_inc  = 1'b1;
        w_cnt_inc = 1'b1;
        w_set_unf = 1'b1;
      end else begin
        w_wr_en  = 1'b1;
        w_wr_idx = w_top_idx;
        w_do_pop = 1'b1;
      end
    end else if (push) begin
      if (!w_full) begin
        w_wr_en   = 1'b1;
        w_sp_inc  = 1'b1;
        w_cnt_inc = 1'b1;
      end else begin
        w_set_ovf = 1'b1;
`ifdef RAS_WRAP_EN
        w_wr_en   = 1'b1;
        w_sp_inc  = 1'b1;
`endif
      end
    end else if (pop) begin
      if (!w_empty) begin
        w_do_pop  = 1'b1;
        w_sp_dec  = 1'b1;
        w_cnt_dec = 1'b1;
      end else begin
        w_set_unf = 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) r_mem[w_wr_idx] <= push_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp        <= '0;
      r_count     <= '0;
      r_pop_addr  <= '0;
      r_pop_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_pop_valid <= w_do_pop;
      if (w_do_pop) r_pop_addr <= r_mem[w_top_idx];
      if (w_sp_inc)      r_sp <= r_sp + PTR_W'(1);
      else if (w_sp_dec) r_sp <= r_sp - PTR_W'(1);
      if (w_cnt_inc)      r_count <= r_count + CNT_W'(1);
      else if (w_cnt_dec) r_count <= r_count - CNT_W'(1);
      r_ovf <= w_set_ovf | (r_ovf & ~clr_err);
      r_unf <= w_set_unf | (r_unf & ~clr_err);
    end
  end

  assign pop_addr  = r_pop_addr;
  assign pop_valid = r_pop_valid;
  assign top_addr  = w_empty ? '0 : r_mem[w_top_idx];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Scoreboard bench for ret_addr_stack: a queue model of the stack feeds expected pop values.
module tb_ret_addr_stack;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_addr = '0;
  logic       pop = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] pop_addr;
  logic       pop_valid;
  logic [7:0] top_addr;
  logic [3:0] count;
  logic       empty, full, overflow, underflow;

  ret_addr_stack #(.ADDR_W(8), .DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .pop(pop),
    .clr_err(clr_err), .pop_addr(pop_addr), .pop_valid(pop_valid),
    .top_addr(top_addr), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  bit         exp_vld;
  bit         m_ovf, m_unf;
  logic [7:0] m_pa;

  task automatic do_reset();
    rst = 1'b1;
    model.delete(); exp_q.delete();
    exp_vld = 0; m_ovf = 0; m_unf = 0; m_pa = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives one cycle and advances the model; expected pop values go to exp_q.
  task automatic step(input bit p, input logic [7:0] a, input bit q, input bit c);
    bit so, su;
    so = 0; su = 0; exp_vld = 0;
    push = p; push_addr = a; pop = q; clr_err = c;
    if (p && q) begin
      if (model.size() == 0) begin model.push_back(a); su = 1; end
      else begin exp_q.push_back(model.pop_back()); model.push_back(a); exp_vld = 1; end
    end else if (p) begin
      if (model.size() < 8) model.push_back(a);
      else begin
        so = 1;
`ifdef RAS_WRAP_EN
        void'(model.pop_front());
        model.push_back(a);
`endif
      end
    end else if (q) begin
      if (model.size() > 0) begin exp_q.push_back(model.pop_back()); exp_vld = 1; end
      else su = 1;
    end
    m_ovf = so | (m_ovf & !c);
    m_unf = su | (m_unf & !c);
    @(posedge clk); #1;
    push = 0; pop = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++;
      $display("FAIL reset_count count=%0d empty=%b full=%b required 0/1/0", count, empty, full); end
    checks++; if (pop_valid !== 1'b0 || pop_addr !== 8'h00 || top_addr !== 8'h00) begin failures++;
      $display("FAIL reset_out pv=%b pa=%h top=%h required 0/00/00", pop_valid, pop_addr, top_addr); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++;
      $display("FAIL reset_flags ovf=%b unf=%b required 0/0", overflow, underflow); end
  endtask

  task automatic test_lifo();
    logic [7:0] vals[3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] e;
    for (int i = 0; i < 3; i++) step(1, vals[i], 0, 0);
    checks++; if (count !== 4'd3 || top_addr !== 8'h33) begin failures++;
      $display("FAIL lifo_fill count=%0d top=%h required 3/33", count, top_addr); end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1, 0);
      checks++; if (pop_valid !== exp_vld || exp_q.size() == 0) begin failures++;
        $display("FAIL lifo_pv%0d pv=%b required %b", i, pop_valid, exp_vld); end
      else begin
        e = exp_q.pop_front(); m_pa = e;
        checks++; if (pop_addr !== e || count !== 4'(model.size())) begin failures++;
          $display("FAIL lifo_pop%0d pa=%h count=%0d required %h/%0d", i, pop_addr, count, e, model.size()); end
      end
    end
    step(0, 8'h00, 0, 0);
    checks++; if (pop_valid !== 1'b0 || empty !== 1'b1 || count !== 4'd0) begin failures++;
      $display("FAIL lifo_end pv=%b empty=%b count=%0d required 0/1/0", pop_valid, empty, count); end
  endtask

  task automatic test_underflow();
    step(0, 8'h00, 1, 0);
    checks++; if (underflow !== m_unf || pop_valid !== 1'b0 || pop_addr !== m_pa || count !== 4'd0) begin failures++;
      $display("FAIL underflow unf=%b pv=%b pa=%h count=%0d required %b/0/%h/0", underflow, pop_valid, pop_addr, count, m_unf, m_pa); end
    step(0, 8'h00, 1, 1);
    checks++; if (underflow !== 1'b1) begin failures++;
      $display("FAIL clr_vs_set unf=%b required 1", underflow); end
    step(0, 8'h00, 0, 1);
    checks++; if (underflow !== m_unf) begin failures++;
      $display("FAIL clr_err unf=%b required %b", underflow, m_unf); end
  endtask

  task automatic test_full();
    logic [7:0] e;
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
    checks++; if (full !== 1'b1 || count !== 4'd8 || top_addr !== 8'h08) begin failures++;
      $display("FAIL full_fill full=%b count=%0d top=%h required 1/8/08", full, count, top_addr); end
    step(1, 8'h99, 0, 0);
    checks++; if (overflow !== m_ovf || count !== 4'd8) begin failures++;
      $display("FAIL full_ovf ovf=%b count=%0d required %b/8", overflow, count, m_ovf); end
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 1, 0);
      checks++; if (pop_valid !== 1'b1 || exp_q.size() == 0) begin failures++;
        $display("FAIL full_pv%0d pv=%b required 1", i, pop_valid); end
      else begin
        e = exp_q.pop_front(); m_pa = e;
        checks++; if (pop_addr !== e) begin failures++;
          $display("FAIL full_pop%0d pa=%h required %h", i, pop_addr, e); end
      end
    end
    checks++; if (empty !== 1'b1 || count !== 4'd0) begin failures++;
      $display("FAIL full_drain empty=%b count=%0d required 1/0", empty, count); end
  endtask

  task automatic test_push_pop();
    logic [7:0] e;
    do_reset();
    step(1, 8'h40, 0, 0);
    step(1, 8'h41, 0, 0);
    step(1, 8'h50, 1, 0);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (pop_valid !== 1'b1 || pop_addr !== e || count !== 4'd2 || top_addr !== 8'h50) begin failures++;
      $display("FAIL pushpop pv=%b pa=%h count=%0d top=%h required 1/%h/2/50", pop_valid, pop_addr, count, top_addr, e); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++;
      $display("FAIL pushpop_flags ovf=%b unf=%b required 0/0", overflow, underflow); end
    step(0, 8'h00, 1, 0);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (pop_valid !== 1'b1 || pop_addr !== e) begin failures++;
      $display("FAIL pushpop_next pv=%b pa=%h required 1/%h", pop_valid, pop_addr, e); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 8'hA0, 0, 0);
    step(1, 8'hA1, 0, 0);
    push = 1; push_addr = 8'hA2;
    do_reset();
    push = 0;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || top_addr !== 8'h00 || pop_valid !== 1'b0) begin failures++;
      $display("FAIL rst_mid count=%0d empty=%b top=%h pv=%b required 0/1/00/0", count, empty, top_addr, pop_valid); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++;
      $display("FAIL rst_mid_flags ovf=%b unf=%b required 0/0", overflow, underflow); end
    step(0, 8'h00, 1, 0);
    checks++; if (underflow !== m_unf || pop_valid !== 1'b0) begin failures++;
      $display("FAIL rst_mid_pop unf=%b pv=%b required %b/0", underflow, pop_valid, m_unf); end
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    step(1, 8'h77, 1, 0);
    checks++; if (count !== 4'd1 || top_addr !== 8'h77 || underflow !== m_unf || pop_valid !== 1'b0) begin failures++;
      $display("FAIL empty_pushpop count=%0d top=%h unf=%b pv=%b required 1/77/%b/0", count, top_addr, underflow, pop_valid, m_unf); end
    checks++; if (pop_addr !== m_pa) begin failures++;
      $display("FAIL empty_pushpop_pa pa=%h required %h", pop_addr, m_pa); end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_underflow();
    test_full();
    test_push_pop();
    test_reset_mid();
    test_empty_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
